// File: rtl/interrupt_ctrl_if.sv
// interrupt_ctrl_if: CPU data bus between the core and the interrupt controller registers
interface interrupt_ctrl_if;
  logic        clk_en;
  logic [11:0] memory_addr;
  logic        memory_read_en;
  logic        memory_write_en;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;
  logic        bus_hit;
  modport master (
    output clk_en, memory_addr, memory_read_en, memory_write_en, memory_write_data,
    input  memory_read_data, bus_hit
  );
  modport slave (
    input  clk_en, memory_addr, memory_read_en, memory_write_en, memory_write_data,
    output memory_read_data, bus_hit
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: event flags, masks, button synchronizers and registered interrupt requests
module interrupt_ctrl (
  input  logic              clk,
  input  logic              reset_n,
  interrupt_ctrl_if.slave   bus,
  input  logic [3:0]        clock_timer_evt,
  input  logic [1:0]        stopwatch_evt,
  input  logic              prog_timer_evt,
  input  logic              serial_evt,
  input  logic [3:0]        input_k0,
  input  logic              input_k1,
  output logic [14:0]       interrupt_req
);
  logic [3:0] it, eit, eik0, dfk0, k0_m, k0_s, k0_d, rdata;
  logic [1:0] isw, eisw;
  logic       ipt, isio, ik0, ik1, eipt, eisio, eik1, k1_m, k1_s, k1_d, hit, rd, wr;
  logic [11:0] a;
  assign a  = bus.memory_addr;
  assign rd = bus.clk_en & bus.memory_read_en;
  assign wr = bus.clk_en & bus.memory_write_en;
  assign bus.memory_read_data = rdata;
  assign bus.bus_hit = hit;
  // zero-latency register read mux and address decode
  always_comb begin
    rdata = 4'h0;
    hit   = 1'b1;
    case (a)
      12'hE00: rdata = it;
      12'hE01: rdata = {2'b0, isw};
      12'hE02: rdata = {3'b0, ipt};
      12'hE03: rdata = {3'b0, isio};
      12'hE04: rdata = {3'b0, ik0};
      12'hE05: rdata = {3'b0, ik1};
      12'hE10: rdata = eit;
      12'hE11: rdata = {2'b0, eisw};
      12'hE12: rdata = {3'b0, eipt};
      12'hE13: rdata = {3'b0, eisio};
      12'hE14: rdata = eik0;
      12'hE15: rdata = {3'b0, eik1};
      12'hE40: rdata = k0_s;
      12'hE41: rdata = dfk0;
      12'hE42: rdata = {3'b0, k1_s};
      default: hit = 1'b0;
    endcase
  end
  // flags: events always set, a qualified read clears, and a coincident event wins over the clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      it   <= 4'h0;
      isw  <= 2'b0;
      ipt  <= 1'b0;
      isio <= 1'b0;
      ik0  <= 1'b0;
      ik1  <= 1'b0;
    end else begin
      it   <= (rd && a == 12'hE00 ? 4'h0 : it) | clock_timer_evt;
      isw  <= (rd && a == 12'hE01 ? 2'b0 : isw) | stopwatch_evt;
      ipt  <= (rd && a == 12'hE02 ? 1'b0 : ipt) | prog_timer_evt;
      isio <= (rd && a == 12'hE03 ? 1'b0 : isio) | serial_evt;
      ik0  <= (rd && a == 12'hE04 ? 1'b0 : ik0) | |((k0_s ^ k0_d) & (k0_s ^ dfk0) & eik0);
      ik1  <= (rd && a == 12'hE05 ? 1'b0 : ik1) | (k1_d & ~k1_s & eik1);
    end
  // mask and K0 compare registers written from the CPU bus
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      eit   <= 4'h0;
      eisw  <= 2'b0;
      eipt  <= 1'b0;
      eisio <= 1'b0;
      eik0  <= 4'h0;
      eik1  <= 1'b0;
      dfk0  <= 4'hF;
    end else if (wr) begin
      eit   <= a == 12'hE10 ? bus.memory_write_data : eit;
      eisw  <= a == 12'hE11 ? bus.memory_write_data[1:0] : eisw;
      eipt  <= a == 12'hE12 ? bus.memory_write_data[0] : eipt;
      eisio <= a == 12'hE13 ? bus.memory_write_data[0] : eisio;
      eik0  <= a == 12'hE14 ? bus.memory_write_data : eik0;
      eik1  <= a == 12'hE15 ? bus.memory_write_data[0] : eik1;
      dfk0  <= a == 12'hE41 ? bus.memory_write_data : dfk0;
    end
  // two-flop pin synchronizers plus one delayed copy for change detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {k0_m, k0_s, k0_d} <= 12'hFFF;
      {k1_m, k1_s, k1_d} <= 3'b111;
    end else begin
      {k0_m, k0_s, k0_d} <= {input_k0, k0_m, k0_s};
      {k1_m, k1_s, k1_d} <= {input_k1, k1_m, k1_s};
    end
  // requests registered from flags and masks; IK0 is already mask-qualified when set
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) interrupt_req <= 15'h0;
    else interrupt_req <= {9'h0, |(it & eit), |(isw & eisw), ik0, ik1 & eik1, isio & eisio, ipt & eipt};
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: scoreboard bench for interrupt_ctrl registers, flags and requests
module tb_interrupt_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] clock_timer_evt = 4'h0;
  logic [1:0] stopwatch_evt = 2'b0;
  logic prog_timer_evt = 1'b0;
  logic serial_evt = 1'b0;
  logic [3:0] input_k0 = 4'hF;
  logic input_k1 = 1'b1;
  logic [14:0] interrupt_req;
  int n_chk = 0;
  int n_fail = 0;
  string tq[$];
  logic [15:0] eq[$];
  interrupt_ctrl_if bif ();
  interrupt_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bus(bif),
    .clock_timer_evt(clock_timer_evt), .stopwatch_evt(stopwatch_evt),
    .prog_timer_evt(prog_timer_evt), .serial_evt(serial_evt),
    .input_k0(input_k0), .input_k1(input_k1), .interrupt_req(interrupt_req)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [15:0] exp);
    tq.push_back(tag);
    eq.push_back(exp);
  endtask
  task automatic pop_chk(input logic [15:0] got);
    if (tq.size() == 0) chk("sb_empty", 16'h1, 16'h0);
    else chk(tq.pop_front(), got, eq.pop_front());
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr_reg(input logic [11:0] a, input logic [3:0] d);
    bif.clk_en = 1'b1;
    bif.memory_addr = a;
    bif.memory_write_data = d;
    bif.memory_write_en = 1'b1;
    tick();
    bif.memory_write_en = 1'b0;
  endtask
  task automatic rd_reg(input string tag, input logic [11:0] a, input logic [3:0] exp);
    bif.clk_en = 1'b1;
    bif.memory_addr = a;
    bif.memory_read_en = 1'b1;
    push(tag, {12'h0, exp});
    #1;
    pop_chk({12'h0, bif.memory_read_data});
    tick();
    bif.memory_read_en = 1'b0;
  endtask
  task automatic irq_after(input string tag, input logic [14:0] exp);
    push(tag, {1'b0, exp});
    tick();
    pop_chk({1'b0, interrupt_req});
  endtask
  initial begin
    bif.clk_en = 1'b0;
    bif.memory_addr = 12'h0;
    bif.memory_read_en = 1'b0;
    bif.memory_write_en = 1'b0;
    bif.memory_write_data = 4'h0;
    tick(2);
    push("rst_irq", 16'h0);
    pop_chk({1'b0, interrupt_req});
    rd_reg("rst_dfk0", 12'hE41, 4'hF);
    rd_reg("rst_k0", 12'hE40, 4'hF);
    rd_reg("rst_k1", 12'hE42, 4'h1);
    rd_reg("rst_eit", 12'hE10, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bif.memory_addr = 12'hE20;
    push("miss_hit", 16'h0);
    push("miss_data", 16'h0);
    #1;
    pop_chk({15'h0, bif.bus_hit});
    pop_chk({12'h0, bif.memory_read_data});
    bif.memory_addr = 12'hE15;
    push("hit", 16'h1);
    #1;
    pop_chk({15'h0, bif.bus_hit});
    wr_reg(12'hE10, 4'h8);
    rd_reg("eit_wr", 12'hE10, 4'h8);
    clock_timer_evt = 4'h8;
    irq_after("it_edge", 15'h0);
    clock_timer_evt = 4'h0;
    irq_after("it_req", 15'h0020);
    rd_reg("it_read", 12'hE00, 4'h8);
    irq_after("it_clr_req", 15'h0);
    wr_reg(12'hE00, 4'hF);
    rd_reg("ro_ignored", 12'hE00, 4'h0);
    stopwatch_evt = 2'b01;
    tick();
    stopwatch_evt = 2'b00;
    irq_after("sw_masked", 15'h0);
    wr_reg(12'hE11, 4'h1);
    irq_after("sw_unmask", 15'h0010);
    rd_reg("sw_read", 12'hE01, 4'h1);
    irq_after("sw_clr_req", 15'h0);
    clock_timer_evt = 4'h1;
    rd_reg("race_read", 12'hE00, 4'h0);
    clock_timer_evt = 4'h0;
    rd_reg("race_flag", 12'hE00, 4'h1);
    wr_reg(12'hE14, 4'h1);
    input_k0 = 4'hE;
    tick(3);
    irq_after("k0_req", 15'h0008);
    rd_reg("k0_flag", 12'hE04, 4'h1);
    irq_after("k0_clr_req", 15'h0);
    rd_reg("k0_pins", 12'hE40, 4'hE);
    input_k0 = 4'hF;
    tick(4);
    rd_reg("k0_back_eq", 12'hE04, 4'h0);
    wr_reg(12'hE41, 4'hE);
    tick(3);
    rd_reg("dfk0_no_flag", 12'hE04, 4'h0);
    rd_reg("dfk0_val", 12'hE41, 4'hE);
    input_k0 = 4'hE;
    tick(4);
    rd_reg("k0_to_eq", 12'hE04, 4'h0);
    input_k0 = 4'hF;
    tick(4);
    rd_reg("k0_to_ne", 12'hE04, 4'h1);
    wr_reg(12'hE15, 4'h1);
    input_k1 = 1'b0;
    tick(3);
    irq_after("k1_req", 15'h0004);
    rd_reg("k1_flag", 12'hE05, 4'h1);
    rd_reg("k1_pin", 12'hE42, 4'h0);
    push("k1_clr_req", 16'h0);
    pop_chk({1'b0, interrupt_req});
    input_k1 = 1'b1;
    tick(4);
    rd_reg("k1_rise", 12'hE05, 4'h0);
    wr_reg(12'hE13, 4'h1);
    serial_evt = 1'b1;
    tick();
    serial_evt = 1'b0;
    irq_after("sio_req", 15'h0002);
    rd_reg("sio_flag", 12'hE03, 4'h1);
    wr_reg(12'hE12, 4'h1);
    prog_timer_evt = 1'b1;
    tick();
    prog_timer_evt = 1'b0;
    irq_after("pt_req", 15'h0001);
    bif.memory_addr = 12'hE02;
    #2;
    reset_n = 1'b0;
    push("async_irq", 16'h0);
    push("async_ipt", 16'h0);
    #1;
    pop_chk({1'b0, interrupt_req});
    pop_chk({12'h0, bif.memory_read_data});
    bif.memory_addr = 12'hE12;
    push("async_eipt", 16'h0);
    #1;
    pop_chk({12'h0, bif.memory_read_data});
    tick(2);
    @(negedge clk);
    reset_n = 1'b1;
    clock_timer_evt = 4'h4;
    tick();
    clock_timer_evt = 4'h0;
    rd_reg("first_evt", 12'hE00, 4'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port clk_en, input, 1, CPU bus qualifier; register accesses take effect only on cycles where it is high.
REQ-004 The block SHALL have port clock_timer_evt, input, 4, single-clk event pulses [3]=32Hz [2]=8Hz [1]=2Hz [0]=1Hz.
REQ-005 The block SHALL have port stopwatch_evt, input, 2, single-clk event pulses [1]=10Hz [0]=1Hz.
REQ-006 The block SHALL have port prog_timer_evt, input, 1, programmable timer underflow pulse.
REQ-007 The block SHALL have port serial_evt, input, 1, serial transfer complete pulse.
REQ-008 The block SHALL have port input_k0, input, 4, asynchronous K00-K03 button pins.
REQ-009 The block SHALL have port input_k1, input, 1, asynchronous K10 pin.
REQ-010 The block SHALL have port memory_addr, input, 12, CPU data address.
REQ-011 The block SHALL have ports memory_read_en and memory_write_en, input, 1 each, CPU access strobes.
REQ-012 The block SHALL have port memory_write_data, input, 4, CPU write nibble.
REQ-013 The block SHALL have port memory_read_data, output, 4, read nibble; 0 when not addressed.
REQ-014 The block SHALL have port bus_hit, output, 1, high when memory_addr decodes to a register of this block.
REQ-015 The block SHALL have port interrupt_req, output, 15, level requests to the CPU.

Function
REQ-016 Register map (R=read, W=write): 0xE00 IT flags R; 0xE01 ISW flags [1:0] R; 0xE02 IPT [0] R; 0xE03 ISIO [0] R; 0xE04 IK0 [0] R; 0xE05 IK1 [0] R; 0xE10 EIT R/W; 0xE11 EISW [1:0] R/W; 0xE12 EIPT [0] R/W; 0xE13 EISIO [0] R/W; 0xE14 EIK0 [3:0] R/W; 0xE15 EIK1 [0] R/W; 0xE40 K0 synchronized pins R; 0xE41 DFK0 R/W; 0xE42 K1 synchronized pin [0] R.
REQ-017 Unused bits SHALL read 0, and writes to read-only addresses SHALL be ignored.
REQ-018 memory_read_data and bus_hit SHALL be combinational from memory_addr, with zero latency.
REQ-019 A flag bit SHALL set on any clk cycle where its event is high, regardless of clk_en or mask.
REQ-020 A read of a flag address (clk_en and memory_read_en high) SHALL return the current flags and clear them at that clock edge.
REQ-021 If an event and a clearing read coincide, the bit SHALL remain 1; the read returns the pre-edge value.
REQ-022 input_k0 and input_k1 SHALL pass through 2-flop synchronizers reset to 1.
REQ-023 IK0 SHALL set when any synchronized K0 bit i changes from equal-DFK0[i] to not-equal while EIK0[i]=1.
REQ-024 A DFK0 write that makes a pin unequal SHALL NOT set IK0.
REQ-025 IK1 SHALL set on a synchronized K1 falling edge while EIK1=1.
REQ-026 interrupt_req[0] = |(IPT&EIPT); [1] = |(ISIO&EISIO); [2] = |(IK1&EIK1); [3] = |IK0 (already mask-qualified); [4] = |(ISW&EISW); [5] = |(IT&EIT); [14:6] = 0.
REQ-027 interrupt_req SHALL be registered, 1 clk after the flag or mask change.
REQ-028 A request SHALL stay asserted until its flag is read-cleared or its mask cleared.

Reset
REQ-029 While reset_n=0: all flags=0, all masks=0, DFK0=4'hF, synchronizers=1, interrupt_req=0.
REQ-030 Reset assertion mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-031 After reset deassertion, the first event SHALL be captured on the next edge.

Verification
REQ-032 Write EIT=4'h8, pulse clock_timer_evt=4'h8 -> interrupt_req=15'h0020 one clk later; read 0xE00 -> data 4'h8, then interrupt_req=0.
REQ-033 Pulse stopwatch_evt=2'b01 with EISW=0 -> ISW reads 2'b01 and interrupt_req[4]=0; write EISW=1 before the read -> interrupt_req[4]=1.
REQ-034 Read 0xE00 in the same cycle as a 1Hz pulse -> read data 0, flag then reads 4'h1.
REQ-035 EIK0=4'h1, DFK0=4'hF, drive input_k0[0] low -> IK0=1 after 2 synchronizer clks plus 1; DFK0 write 4'hE alone -> no IK0.
REQ-036 Set IPT with EIPT=1, assert reset_n=0 between edges -> interrupt_req=0 and 0xE02 reads 0 immediately.
